est_seq_ctrl: RTL
=================

# est_seq_ctrl

Parametrised sequencing controller for the uplink channel-estimation datapath. It succeeds the fixed 12-subcarrier estimation controller.
- Triggered by the pilot symbol number.
- Walks a run-time-configurable contiguous subcarrier window (3/6/12-tone style allocations, generalised to NSC_MAX).
- Back-pressures on a downstream ready, pulses completion, and re-arms on the release symbol.
- Drives the estimator index mux, the per-subcarrier done strobes and the serial-to-parallel reset.

## Interface
Parameters:
- NSC_MAX, 12, maximum subcarriers; width of o_est_done.
- IDX_W, $clog2(NSC_MAX), width of o_indx, i_sc_start and the internal counter.
- SYM_W, 3, width of i_symbol_num.
- PILOT_SYM, 4, symbol number that starts estimation.
- RELEASE_SYM, 5, symbol number that re-arms the controller from READY.

Ports:
- i_clk_est  in  1  block clock; all logic on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_symbol_num  in  SYM_W  current symbol number (level).
- i_num_sc  in  IDX_W+1  active subcarrier count. Sampled at start.
- i_sc_start  in  IDX_W  first subcarrier index of the allocation. Sampled at start.
- i_est_ready  in  1  estimator accepts the current index this cycle.
- o_indx  out  IDX_W  subcarrier index presented to the estimator.
- o_est_done  out  NSC_MAX  one-hot strobe: bit o_indx high on each accepted transfer.
- o_rst_ser_par  out  1  active-low reset pulse to the serial-to-parallel block.
- o_busy  out  1  high while in RUN.
- o_all_done  out  1  one-cycle pulse on the last accepted transfer.
- o_overrun  out  1  sticky pilot-while-busy flag (see Configuration).

## Operation
- States: WAIT_INPUT, RUN, READY. Reset state is WAIT_INPUT.
- WAIT_INPUT:
  - If i_symbol_num==PILOT_SYM: o_rst_ser_par=0 (combinational, same cycle), latch i_sc_start and the effective count K, clear the counter, then go to RUN.
  - Otherwise stay.
- Effective count K = min(i_num_sc, NSC_MAX−i_sc_start).
  - If K==0: skip RUN, go directly to READY, and pulse o_all_done in the WAIT_INPUT cycle.
- RUN:
  - o_indx = latched start + counter; o_busy=1.
  - When i_est_ready=1: o_est_done[o_indx]=1 and the counter increments.
  - When i_est_ready=0: o_est_done=0 and o_indx holds.
  - On the accepted transfer with counter==K−1: pulse o_all_done, then go to READY.
- READY: go to WAIT_INPUT when i_symbol_num==RELEASE_SYM, else stay. No estimation occurs in READY even if the pilot number persists.
- Outputs are Moore-style from state and counter, except o_est_done/o_all_done (gated by i_est_ready) and o_rst_ser_par (gated by i_symbol_num).
- Defaults in every state: o_indx=0 outside RUN, o_est_done=0, o_rst_ser_par=1, o_all_done=0.
- Index arithmetic never exceeds NSC_MAX−1 because of the clipping of K; no wrap-around.
- Reset mid-RUN: return immediately to WAIT_INPUT, counter 0, all outputs at their reset values. A partial sequence is abandoned.

## Timing
- Reset values:
  - o_indx=0, o_est_done=0, o_rst_ser_par=1, o_busy=0, o_all_done=0, o_overrun=0.
  - State WAIT_INPUT, counter 0, latched start 0, latched K 0.
- Pilot seen in cycle N (WAIT_INPUT): o_rst_ser_par low in N; RUN from N+1.
- With i_est_ready held high:
  - Indices start..start+K−1 appear in cycles N+1..N+K.
  - o_all_done in cycle N+K; READY from N+K+1.
- Each low cycle of i_est_ready adds one cycle of latency.
- RELEASE_SYM observed in READY at cycle M: WAIT_INPUT at M+1; a new pilot can be accepted from M+1.

## Configuration
- EST_OVERRUN_CHK_EN defined:
  - i_symbol_num==PILOT_SYM observed while in RUN, on a cycle where the previous cycle's symbol number differed (new pilot edge), sets o_overrun.
  - o_overrun stays set until i_rst.
  - The running sequence continues unaffected.
- Not defined: o_overrun tied to 0 and the edge-detect register is removed.

## Structure
- Shared package est_pkg:
  - State enum est_state_t with explicit binary encoding (WAIT_INPUT=2'b00, RUN=2'b01, READY=2'b10).
  - Default constants EST_NSC_MAX=12, EST_PILOT_SYM=4, EST_RELEASE_SYM=5.
- Single module with the counter inline; no sub-module is warranted.

## Test plan
- Full allocation: NSC_MAX=12, i_num_sc=12, i_sc_start=0, ready=1, pilot (4) at cycle 10 → o_rst_ser_par=0 at 10; o_indx 0..11 and o_est_done=1<<idx at 11..22; o_all_done at 22; READY until symbol 5.
- 3-tone window: i_num_sc=3, i_sc_start=6 → indices 6,7,8; o_est_done 0x040, 0x080, 0x100; o_all_done on index 8.
- Back-pressure: 12 tones with ready low for 2 cycles at index 5 → index 5 held for 3 cycles with o_est_done=0 while ready is low; o_all_done 2 cycles later than the unstalled case.
- Clipping and zero count:
  - i_num_sc=8, i_sc_start=9 → only 9,10,11 issued.
  - i_num_sc=0 → o_all_done in the pilot cycle, no o_est_done, direct to READY.
- Reset and re-arm:
  - i_rst asserted at index 4 → all outputs immediately at reset values; the next pilot restarts at start index.
  - Pilot held through READY → no second run until symbol 5 is seen and a fresh pilot arrives.
- EST_OVERRUN_CHK_EN: pilot re-edge during RUN → o_overrun=1 from the next cycle and held; the sequence still completes all K indices. Without the macro → o_overrun stays 0.

Source files
------------

// File: rtl/est_pkg.sv
// Shared types and defaults for the uplink channel-estimation sequencer.
package est_pkg;

  typedef enum logic [1:0] {
    WAIT_INPUT = 2'b00,
    RUN        = 2'b01,
    READY      = 2'b10
  } est_state_t;

  localparam int unsigned EST_NSC_MAX     = 12;
  localparam int unsigned EST_PILOT_SYM   = 4;
  localparam int unsigned EST_RELEASE_SYM = 5;

  // Window length clipped so start+K never runs past the last subcarrier.
  function automatic int unsigned est_eff_count(input int unsigned num_sc,
                                                input int unsigned sc_start,
                                                input int unsigned nsc_max);
    int unsigned room;
    room = (sc_start >= nsc_max) ? 32'd0 : nsc_max - sc_start;
    return (num_sc < room) ? num_sc : room;
  endfunction

endpackage

// File: rtl/est_seq_ctrl.sv
// Channel-estimation sequencer: walks a clipped subcarrier window on each pilot symbol.
// Optional pilot-while-busy detection enabled by defining EST_OVERRUN_CHK_EN.
module est_seq_ctrl
  import est_pkg::*;
#(
  parameter int unsigned NSC_MAX     = EST_NSC_MAX,
  parameter int unsigned IDX_W       = $clog2(NSC_MAX),
  parameter int unsigned SYM_W       = 3,
  parameter int unsigned PILOT_SYM   = EST_PILOT_SYM,
  parameter int unsigned RELEASE_SYM = EST_RELEASE_SYM
) (
  input  logic               i_clk_est,
  input  logic               i_rst,
  input  logic [SYM_W-1:0]   i_symbol_num,
  input  logic [IDX_W:0]     i_num_sc,
  input  logic [IDX_W-1:0]   i_sc_start,
  input  logic               i_est_ready,
  output logic [IDX_W-1:0]   o_indx,
  output logic [NSC_MAX-1:0] o_est_done,
  output logic               o_rst_ser_par,
  output logic               o_busy,
  output logic               o_all_done,
  output logic               o_overrun
);

  localparam int unsigned CNT_W = IDX_W + 1;

  est_state_t       state_q;
  logic [IDX_W-1:0] start_q;
  logic [IDX_W-1:0] cnt_q;
  logic [CNT_W-1:0] k_q;

  logic             pilot_c;
  logic             release_c;
  logic             last_c;
  logic [CNT_W-1:0] k_c;
  logic [IDX_W-1:0] idx_c;

  assign pilot_c   = (i_symbol_num == SYM_W'(PILOT_SYM));
  assign release_c = (i_symbol_num == SYM_W'(RELEASE_SYM));
  assign k_c       = CNT_W'(est_eff_count(32'(i_num_sc), 32'(i_sc_start), NSC_MAX));
  assign last_c    = ({1'b0, cnt_q} == (k_q - CNT_W'(1)));
  assign idx_c     = start_q + cnt_q;

  always_ff @(posedge i_clk_est or posedge i_rst) begin
    if (i_rst) begin
      state_q <= WAIT_INPUT;
      start_q <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      case (state_q)
        WAIT_INPUT: begin
          if (pilot_c) begin
            start_q <= i_sc_start;
            k_q     <= k_c;
            cnt_q   <= '0;
            state_q <= (k_c == '0) ? READY : RUN;
          end
        end
        RUN: begin
          if (i_est_ready) begin
            if (last_c) state_q <= READY;
            else        cnt_q   <= cnt_q + IDX_W'(1);
          end
        end
        READY: begin
          if (release_c) state_q <= WAIT_INPUT;
        end
        default: state_q <= WAIT_INPUT;
      endcase
    end
  end

  // Moore outputs from state/counter; strobes gated by ready, ser/par reset by the pilot.
  always_comb begin
    o_indx        = '0;
    o_est_done    = '0;
    o_rst_ser_par = 1'b1;
    o_all_done    = 1'b0;
    o_busy        = 1'b0;
    if (!i_rst) begin
      case (state_q)
        WAIT_INPUT: begin
          if (pilot_c) begin
            o_rst_ser_par = 1'b0;
            o_all_done    = (k_c == '0);
          end
        end
        RUN: begin
          o_busy = 1'b1;
          o_indx = idx_c;
          if (i_est_ready) begin
            o_est_done = NSC_MAX'(1) << idx_c;
            o_all_done = last_c;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EST_OVERRUN_CHK_EN
  logic pilot_prev_q;
  logic overrun_q;

  // A fresh pilot edge while a window is still being walked is sticky until reset.
  always_ff @(posedge i_clk_est or posedge i_rst) begin
    if (i_rst) begin
      pilot_prev_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      pilot_prev_q <= pilot_c;
      if ((state_q == RUN) && pilot_c && !pilot_prev_q) overrun_q <= 1'b1;
    end
  end

  assign o_overrun = overrun_q;
`else
  assign o_overrun = 1'b0;
`endif

endmodule
